// File: rtl/usb_crc_rx_check_if.sv
// Serial receive-path bundle between the bit-unstuffer, the CRC checker and the
// protocol handler. The master drives the bit stream and the slave returns payload and verdict.
interface usb_crc_rx_check_if;
  logic in_valid;
  logic in_bit;
  logic sop;
  logic eop;
  logic mode;
  logic out_valid;
  logic out_bit;
  logic done;
  logic crc_ok;
  logic crc_err;
  logic len_err;
  logic busy;

  modport master (
    output in_valid, in_bit, sop, eop, mode,
    input  out_valid, out_bit, done, crc_ok, crc_err, len_err, busy
  );

  modport slave (
    input  in_valid, in_bit, sop, eop, mode,
    output out_valid, out_bit, done, crc_ok, crc_err, len_err, busy
  );
endinterface

// File: rtl/usb_crc_rx_check.sv
// Serial USB CRC5/CRC16 receive checker: runs the LSB-first CRC over each packet, strips the
// trailing CRC field through a W-deep delay line and issues a residue verdict one cycle after eop.
module usb_crc_rx_check #(
  parameter int unsigned      W_A    = 5,
  parameter logic [W_A-1:0]   POLY_A = 5'h05,
  parameter logic [W_A-1:0]   RES_A  = 5'h0C,
  parameter int unsigned      W_B    = 16,
  parameter logic [W_B-1:0]   POLY_B = 16'h8005,
  parameter logic [W_B-1:0]   RES_B  = 16'h800D,
  parameter int unsigned      CNT_W  = 11
) (
  input logic              clock,
  input logic              reset_n,
  usb_crc_rx_check_if.slave rx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam logic [CNT_W-1:0] LEN_A   = CNT_W'(W_A);
  localparam logic [CNT_W-1:0] LEN_B   = CNT_W'(W_B);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // One serial CRC step; in mode 0 only the low W_A bits carry state.
  function automatic logic [W_B-1:0] crc_step(input logic [W_B-1:0] r, input logic b,
                                               input logic m);
    logic [W_B-1:0] nxt;
    nxt = '0;
    if (m) begin
      nxt = {r[W_B-2:0], 1'b0} ^ ((b ^ r[W_B-1]) ? POLY_B : '0);
    end else begin
      nxt[W_A-1:0] = {r[W_A-2:0], 1'b0} ^ ((b ^ r[W_A-1]) ? POLY_A : '0);
    end
    return nxt;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [W_B-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_B-1:0]   dly_q, dly_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             len_q, len_d;

  logic [CNT_W-1:0] pkt_w;
  logic [CNT_W-1:0] cnt_inc;
  logic             tap;
  logic             res_match;
  logic             accept_sop;
  logic             emit;

  assign pkt_w      = mode_q ? LEN_B : LEN_A;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign tap        = mode_q ? dly_q[W_B-1] : dly_q[W_A-1];
  assign res_match  = mode_q ? (crc_q == RES_B) : (crc_q[W_A-1:0] == RES_A);
  assign accept_sop = rx.sop && rx.in_valid;
  // A bit leaves the delay line only once W newer bits are known to follow it.
  assign emit       = (cnt_q >= pkt_w);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    mode_d      = mode_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    done_d      = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;
    len_d       = len_q;

    if (accept_sop) begin
      // sop restarts from any state, silently dropping an unterminated packet.
      state_d = S_RUN;
      mode_d  = rx.mode;
      crc_d   = crc_step('1, rx.in_bit, rx.mode);
      cnt_d   = CNT_ONE;
      dly_d   = {dly_q[W_B-2:0], rx.in_bit};
      ok_d    = 1'b0;
      err_d   = 1'b0;
      len_d   = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (rx.eop) begin
            state_d = S_CHECK;
            done_d  = 1'b1;
            if (cnt_q < pkt_w) begin
              len_d = 1'b1;
              ok_d  = 1'b0;
              err_d = 1'b0;
            end else begin
              ok_d  = res_match;
              err_d = !res_match;
            end
          end else if (rx.in_valid) begin
            crc_d       = crc_step(crc_q, rx.in_bit, mode_q);
            cnt_d       = cnt_inc;
            dly_d       = {dly_q[W_B-2:0], rx.in_bit};
            out_valid_d = emit;
            out_bit_d   = emit & tap;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the delay line is reset with the rest of the state so out_bit never exposes stale data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      crc_q       <= '1;
      cnt_q       <= '0;
      dly_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q     <= state_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      len_q       <= len_d;
    end
  end

  assign rx.out_valid = out_valid_q;
  assign rx.out_bit   = out_bit_q;
  assign rx.done      = done_q;
  assign rx.crc_ok    = ok_q;
  assign rx.crc_err   = err_q;
  assign rx.len_err   = len_q;
  assign rx.busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_usb_crc_rx_check.sv
// Self-checking bench for usb_crc_rx_check: directed USB token/data vectors plus random packets
// judged by a reference model that compares the received CRC field with the transmitted CRC.
module tb_usb_crc_rx_check;
  localparam int W0 = 5;
  localparam int W1 = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   got[$];
  bit   pkt[$];
  logic v_ok, v_err, v_len;

  usb_crc_rx_check_if rx ();

  usb_crc_rx_check dut (
    .clock  (clock),
    .reset_n(reset_n),
    .rx     (rx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (rx.out_valid === 1'b1) got.push_back(rx.out_bit);
    if (rx.done === 1'b1) begin
      done_cnt++;
      v_ok  = rx.crc_ok;
      v_err = rx.crc_err;
      v_len = rx.len_err;
    end
  endtask

  task automatic idle_inputs();
    rx.in_valid = 1'b0;
    rx.in_bit   = 1'b0;
    rx.sop      = 1'b0;
    rx.eop      = 1'b0;
    rx.mode     = 1'b0;
  endtask

  // Transmitter-side CRC: complement of the register after the payload, as a W-bit number.
  function automatic int crc_field(input bit b[$], input int n, input bit m);
    int w, poly, mask, r, fb;
    w    = m ? W1 : W0;
    poly = m ? 'h8005 : 'h05;
    mask = (1 << w) - 1;
    r    = mask;
    for (int i = 0; i < n; i++) begin
      fb = int'(b[i]) ^ ((r >> (w - 1)) & 1);
      r  = ((r << 1) & mask) ^ (fb != 0 ? poly : 0);
    end
    return (~r) & mask;
  endfunction

  // The trailing W bits of a packet read MSB-first, as the field appears on the wire.
  function automatic int rx_field(input bit b[$], input int w);
    int f;
    f = 0;
    for (int k = b.size() - w; k < b.size(); k++) f = (f << 1) | int'(b[k]);
    return f;
  endfunction

  task automatic add_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) pkt.push_back(v[i]);
  endtask

  task automatic add_field(input int f, input int w);
    for (int k = w - 1; k >= 0; k--) pkt.push_back(bit'((f >> k) & 1));
  endtask

  task automatic build_data3();
    pkt.delete();
    add_byte(8'h80); add_byte(8'h06); add_byte(8'h00); add_byte(8'h01);
    add_byte(8'h00); add_byte(8'h00); add_byte(8'h40); add_byte(8'h00);
    add_byte(8'hDD); add_byte(8'h94);
  endtask

  task automatic build_token();
    pkt.delete();
    add_byte(8'h00);
    add_byte(8'h10);
  endtask

  // gap: 0 back-to-back, 1 in_valid every other cycle, 2 random gaps and mid-packet mode noise.
  task automatic drive_bits(input bit b[$], input bit m, input int gap);
    for (int i = 0; i < b.size(); i++) begin
      rx.sop      = (i == 0);
      rx.in_valid = 1'b1;
      rx.in_bit   = b[i];
      rx.mode     = (i == 0 || gap < 2) ? m : 1'($urandom);
      tick();
      if (i == 0) begin
        check("busy_after_sop", 32'(rx.busy), 1);
        check("flags_clr_at_sop", 32'({rx.crc_ok, rx.crc_err, rx.len_err}), 0);
      end
      rx.sop      = 1'b0;
      rx.in_valid = 1'b0;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) tick();
    end
  endtask

  task automatic finish_pkt();
    rx.eop = 1'b1;
    tick();
    check("done_latency", 32'(rx.done), 1);
    rx.eop = 1'b0;
    tick();
    check("done_one_cycle", 32'(rx.done), 0);
    check("busy_after_done", 32'(rx.busy), 0);
  endtask

  task automatic run_expect(input string tag, input bit m, input int gap);
    int w, n, exp_out;
    bit exp_ok, exp_len, bits_ok;
    w = m ? W1 : W0;
    n = pkt.size();
    got.delete();
    done_cnt = 0;
    drive_bits(pkt, m, gap);
    finish_pkt();
    exp_len = (n < w);
    exp_ok  = 1'b0;
    if (!exp_len) exp_ok = (rx_field(pkt, w) == crc_field(pkt, n - w, m));
    exp_out = exp_len ? 0 : n - w;
    check({tag, "_done_count"}, 32'(done_cnt), 1);
    check({tag, "_out_count"}, 32'(got.size()), 32'(exp_out));
    bits_ok = (got.size() == exp_out);
    for (int i = 0; i < exp_out && bits_ok; i++) if (got[i] != pkt[i]) bits_ok = 1'b0;
    check({tag, "_out_bits"}, 32'(bits_ok), 1);
    check({tag, "_crc_ok"}, 32'(v_ok), 32'(exp_ok));
    check({tag, "_crc_err"}, 32'(v_err), 32'(!exp_ok && !exp_len));
    check({tag, "_len_err"}, 32'(v_len), 32'(exp_len));
    check({tag, "_ok_held"}, 32'(rx.crc_ok), 32'(exp_ok));
  endtask

  initial begin
    bit abort_q[$];
    bit tok_q[$];
    bit m;
    int w, kind, n, f, ones;

    idle_inputs();
    #1;
    check("reset_outputs", 32'({rx.out_valid, rx.out_bit, rx.done, rx.crc_ok,
                                rx.crc_err, rx.len_err, rx.busy}), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Stray eop and sop-less bits in IDLE must do nothing.
    got.delete();
    done_cnt = 0;
    rx.eop = 1'b1;
    tick();
    rx.eop      = 1'b0;
    rx.in_valid = 1'b1;
    rx.in_bit   = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    idle_inputs();
    tick();
    check("idle_no_done", 32'(done_cnt), 0);
    check("idle_no_out", 32'(got.size()), 0);
    check("idle_not_busy", 32'(rx.busy), 0);

    // Case 1: clean token, addr 0 endp 0.
    build_token();
    run_expect("t1", 1'b0, 0);
    check("t1_ok_const", 32'(v_ok), 1);
    check("t1_out11", 32'(got.size()), 11);
    ones = 0;
    foreach (got[i]) ones += int'(got[i]);
    check("t1_out_all_zero", 32'(ones), 0);

    // Case 2: same token with bit 3 flipped.
    build_token();
    pkt[3] = ~pkt[3];
    run_expect("t2", 1'b0, 0);
    check("t2_err_const", 32'({v_ok, v_err}), 32'b01);
    check("t2_flipped_bit_out", 32'(got.size() > 3 ? got[3] : 1'b0), 1);

    // Case 3: setup data packet, in_valid every other cycle.
    build_data3();
    run_expect("t3", 1'b1, 1);
    check("t3_ok_const", 32'(v_ok), 1);
    check("t3_out64", 32'(got.size()), 64);

    // Case 4: zero-length data packet, then a 10-bit runt.
    pkt.delete();
    add_byte(8'h00);
    add_byte(8'h00);
    run_expect("t4a", 1'b1, 0);
    check("t4a_ok_const", 32'(v_ok), 1);
    check("t4a_no_out", 32'(got.size()), 0);
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(bit'($urandom_range(0, 1)));
    run_expect("t4b", 1'b1, 0);
    check("t4b_flags_const", 32'({v_ok, v_err, v_len}), 32'b001);

    // Case 5: data packet aborted after 30 bits by a token's sop.
    build_data3();
    abort_q = pkt[0:29];
    build_token();
    tok_q = pkt;
    got.delete();
    done_cnt = 0;
    drive_bits(abort_q, 1'b1, 0);
    check("t5_no_done_abort", 32'(done_cnt), 0);
    got.delete();
    drive_bits(tok_q, 1'b0, 0);
    finish_pkt();
    check("t5_one_done", 32'(done_cnt), 1);
    check("t5_ok", 32'(v_ok), 1);
    check("t5_out11", 32'(got.size()), 11);

    // Case 6: reset pulse mid-packet, then a clean token.
    done_cnt = 0;
    abort_q = tok_q[0:6];
    drive_bits(abort_q, 1'b0, 0);
    check("t6_busy_before_rst", 32'(rx.busy), 1);
    check("t6_outvalid_before_rst", 32'(rx.out_valid), 1);
    reset_n = 1'b0;
    #1;
    check("t6_outputs_in_reset", 32'({rx.out_valid, rx.out_bit, rx.done, rx.crc_ok,
                                      rx.crc_err, rx.len_err, rx.busy}), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_no_done", 32'(done_cnt), 0);
    pkt = tok_q;
    run_expect("t6", 1'b0, 0);
    check("t6_ok_const", 32'(v_ok), 1);

    // Long token-mode packet drives the bit counter into saturation.
    pkt.delete();
    for (int i = 0; i < 2100; i++) pkt.push_back(bit'($urandom_range(0, 1)));
    add_field(crc_field(pkt, pkt.size(), 1'b0), W0);
    run_expect("sat", 1'b0, 0);
    check("sat_ok_const", 32'(v_ok), 1);

    // Random packets: good, corrupted and runt, with gaps and mode noise.
    for (int p = 0; p < 12; p++) begin
      m    = bit'($urandom_range(0, 1));
      w    = m ? W1 : W0;
      kind = $urandom_range(0, 3);
      pkt.delete();
      if (kind == 0) begin
        n = $urandom_range(1, w - 1);
        for (int i = 0; i < n; i++) pkt.push_back(bit'($urandom_range(0, 1)));
      end else begin
        n = $urandom_range(0, m ? 48 : 24);
        for (int i = 0; i < n; i++) pkt.push_back(bit'($urandom_range(0, 1)));
        f = crc_field(pkt, n, m);
        add_field(f, w);
        if (kind == 1) begin
          n = $urandom_range(0, pkt.size() - 1);
          pkt[n] = ~pkt[n];
        end
      end
      run_expect("rand", m, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
